i2c_mst_ctrl_byte: RTL and testbench

//   Byte-level sequencer for the I2C master bit controller.

---
 rtl/i2c_mst_ctrl_byte.sv | 180 ++++++++++++++++++
 tb/tb_i2c_mst_ctrl_byte.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level I2C master sequencer: expands host byte commands into START/READ/WRITE/STOP
// bit commands for the bit controller, shifting data MSB-first and handling the ACK bit.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no command in flight, waiting for a host command
//   ST_START | START / repeated START bit command issued
//   ST_READ  | shifting DW data bits in from the slave
//   ST_WRITE | shifting DW data bits out to the slave
//   ST_ACK   | 9th bit: send ack_in after a read, sample slave ACK after a write
//   ST_STOP  | STOP bit command issued
module i2c_mst_ctrl_byte #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ena,
  input  logic          start,
  input  logic          stop,
  input  logic          read,
  input  logic          write,
  input  logic          ack_in,
  input  logic [DW-1:0] din,
  output logic          cmd_ack,
  output logic          ack_out,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          al,
  output logic [3:0]    bit_cmd,
  input  logic          bit_cmd_ack,
  output logic          bit_din,
  input  logic          bit_dout,
  input  logic          bit_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_READ, ST_WRITE, ST_ACK, ST_STOP
  } state_t;

  state_t        state;
  state_t        route_state;
  logic [3:0]    route_cmd;
  logic [DW-1:0] sr;
  logic [CW-1:0] cnt;

  assign dout = sr;

  // Phase that follows accept (without start) or the START bit; ST_IDLE means the command is done.
  always_comb begin
    route_state = ST_IDLE;
    route_cmd   = CMD_NOP;
    if (read) begin
      route_state = ST_READ;
      route_cmd   = CMD_READ;
    end else if (write) begin
      route_state = ST_WRITE;
      route_cmd   = CMD_WRITE;
    end else if (stop) begin
      route_state = ST_STOP;
      route_cmd   = CMD_STOP;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      bit_cmd <= CMD_NOP;
      cmd_ack <= 1'b0;
      ack_out <= 1'b0;
      sr      <= '0;
      busy    <= 1'b0;
      al      <= 1'b0;
      bit_din <= 1'b1;
      cnt     <= '0;
    end else begin
      cmd_ack <= 1'b0;
      al      <= 1'b0;
      if (bit_al) begin
        // Arbitration loss wins over a coincident bit_cmd_ack; data and ack_out are kept.
        state   <= ST_IDLE;
        bit_cmd <= CMD_NOP;
        busy    <= 1'b0;
        al      <= 1'b1;
      end else if (ena) begin
        case (state)
          ST_IDLE: begin
            if (!cmd_ack && (start || stop || read || write)) begin
              busy <= 1'b1;
              cnt  <= CNT_MAX;
              if (write) begin
                sr      <= din;
                bit_din <= din[DW-1];
              end
              if (start) begin
                state   <= ST_START;
                bit_cmd <= CMD_START;
              end else begin
                state   <= route_state;
                bit_cmd <= route_cmd;
              end
            end
          end
          ST_START: begin
            if (bit_cmd_ack) begin
              state   <= route_state;
              bit_cmd <= route_cmd;
              if (route_state == ST_IDLE) begin
                cmd_ack <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          ST_READ: begin
            if (bit_cmd_ack) begin
              sr <= {sr[DW-2:0], bit_dout};
              if (cnt == '0) begin
                state   <= ST_ACK;
                bit_cmd <= CMD_WRITE;
                bit_din <= ack_in;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          ST_WRITE: begin
            if (bit_cmd_ack) begin
              sr <= {sr[DW-2:0], 1'b0};
              if (cnt == '0) begin
                state   <= ST_ACK;
                bit_cmd <= CMD_READ;
                bit_din <= 1'b1;
              end else begin
                cnt     <= cnt - 1'b1;
                bit_din <= sr[DW-2];
              end
            end
          end
          ST_ACK: begin
            if (bit_cmd_ack) begin
              // A READ bit command in the ACK phase means this byte was a write.
              if (bit_cmd == CMD_READ) ack_out <= bit_dout;
              if (stop) begin
                state   <= ST_STOP;
                bit_cmd <= CMD_STOP;
              end else begin
                state   <= ST_IDLE;
                bit_cmd <= CMD_NOP;
                cmd_ack <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          ST_STOP: begin
            if (bit_cmd_ack) begin
              state   <= ST_IDLE;
              bit_cmd <= CMD_NOP;
              cmd_ack <= 1'b1;
              busy    <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            bit_cmd <= CMD_NOP;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Bench for i2c_mst_ctrl_byte: plays the bit controller and compares each bit command,
// bit_din, dout and ack_out against an expected bit-command list built from the byte command.
module tb_i2c_mst_ctrl_byte;

  localparam int NOP = 0, START = 1, STOP = 2, WRITE = 4, READ = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cmd_ack, ack_out, busy, al, bit_din;
  logic [7:0] dout;
  logic [3:0] bit_cmd;
  logic       bit_cmd_ack = 1'b0, bit_dout = 1'b0, bit_al = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // reference byte-level state
  logic [7:0] m_sr = 8'h00;
  logic       m_ack = 1'b0;

  i2c_mst_ctrl_byte #(.DW(8)) dut (
    .clk(clk), .rstn(rstn), .ena(ena), .start(start), .stop(stop), .read(read),
    .write(write), .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out),
    .dout(dout), .busy(busy), .al(al), .bit_cmd(bit_cmd), .bit_cmd_ack(bit_cmd_ack),
    .bit_din(bit_din), .bit_dout(bit_dout), .bit_al(bit_al)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic drop_cmd();
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // fixed_rd / fixed_sack < 0 means the slave answers with random bits.
  task automatic run_cmd(input bit s, input bit p, input bit r, input bit w,
                         input logic [7:0] d, input bit a,
                         input int fixed_rd, input int fixed_sack,
                         input int abort_at, input int pause_at, input int reset_at,
                         input bit hold);
    int   ecmd[$];
    int   edin[$];
    int   ekind[$];   // 0 control, 1 data bit, 2 ack bit
    bit   ebit[$];
    int   n;
    logic [7:0] rdv;

    rdv = (fixed_rd >= 0) ? 8'(fixed_rd) : 8'($urandom_range(0, 255));
    if (s) begin ecmd.push_back(START); edin.push_back(-1); ekind.push_back(0); ebit.push_back(1'($urandom)); end
    if (r) begin
      for (int i = 7; i >= 0; i--) begin
        ecmd.push_back(READ); edin.push_back(-1); ekind.push_back(1); ebit.push_back(rdv[i]);
      end
      ecmd.push_back(WRITE); edin.push_back(int'(a)); ekind.push_back(2); ebit.push_back(1'($urandom));
    end else if (w) begin
      for (int i = 7; i >= 0; i--) begin
        ecmd.push_back(WRITE); edin.push_back(int'(d[i])); ekind.push_back(1); ebit.push_back(1'($urandom));
      end
      ecmd.push_back(READ); edin.push_back(-1); ekind.push_back(2);
      ebit.push_back((fixed_sack >= 0) ? 1'(fixed_sack) : 1'($urandom));
    end
    if (p) begin ecmd.push_back(STOP); edin.push_back(-1); ekind.push_back(0); ebit.push_back(1'($urandom)); end

    @(negedge clk);
    start = s; stop = p; read = r; write = w; din = d; ack_in = a;
    if (w) m_sr = d;
    @(negedge clk);

    for (int i = 0; i < ecmd.size(); i++) begin
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      if (i == pause_at) begin
        ena = 1'b0;
        repeat (5) @(negedge clk);
        bit_dout = ~ebit[i]; bit_cmd_ack = 1'b1;
        @(negedge clk);
        bit_cmd_ack = 1'b0;
        repeat (14) @(negedge clk);
        check("pause_bit_cmd", 32'(bit_cmd), ecmd[i]);
        check("pause_busy", 32'(busy), 1);
        check("pause_dout", 32'(dout), 32'(m_sr));
        ena = 1'b1;
      end
      check("bit_cmd", 32'(bit_cmd), ecmd[i]);
      check("busy", 32'(busy), 1);
      check("cmd_ack_low", 32'(cmd_ack), 0);
      if (edin[i] >= 0) check("bit_din", 32'(bit_din), edin[i]);

      if (i == abort_at) begin
        bit_al = 1'b1;
        @(negedge clk);
        bit_al = 1'b0;
        drop_cmd();
        check("al_pulse", 32'(al), 1);
        check("al_bit_cmd", 32'(bit_cmd), NOP);
        check("al_busy", 32'(busy), 0);
        check("al_no_cmd_ack", 32'(cmd_ack), 0);
        check("al_dout", 32'(dout), 32'(m_sr));
        @(negedge clk);
        check("al_one_cycle", 32'(al), 0);
        check("al_no_cmd_ack2", 32'(cmd_ack), 0);
        return;
      end

      if (i == reset_at) begin
        #2 rstn = 1'b0;
        #1;
        m_sr = 8'h00; m_ack = 1'b0;
        check("rst_bit_cmd", 32'(bit_cmd), NOP);
        check("rst_cmd_ack", 32'(cmd_ack), 0);
        check("rst_ack_out", 32'(ack_out), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_al", 32'(al), 0);
        check("rst_bit_din", 32'(bit_din), 1);
        drop_cmd();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_after_cmd", 32'(bit_cmd), NOP);
        check("rst_after_cmd_ack", 32'(cmd_ack), 0);
        return;
      end

      bit_dout = ebit[i]; bit_cmd_ack = 1'b1;
      @(negedge clk);
      bit_cmd_ack = 1'b0;
      if (ekind[i] == 1) m_sr = r ? {m_sr[6:0], ebit[i]} : {m_sr[6:0], 1'b0};
      if (ekind[i] == 2 && !r) m_ack = ebit[i];
    end

    check("done_cmd_ack", 32'(cmd_ack), 1);
    check("done_bit_cmd", 32'(bit_cmd), NOP);
    check("done_busy", 32'(busy), 0);
    check("done_dout", 32'(dout), 32'(m_sr));
    check("done_ack_out", 32'(ack_out), 32'(m_ack));
    check("done_al", 32'(al), 0);
    if (hold) begin
      @(negedge clk);
      check("hold_cmd_ack", 32'(cmd_ack), 0);
      check("hold_bit_cmd", 32'(bit_cmd), NOP);
      check("hold_busy", 32'(busy), 0);
    end
    drop_cmd();
    @(negedge clk);
    check("after_cmd_ack", 32'(cmd_ack), 0);
    check("after_bit_cmd", 32'(bit_cmd), NOP);
  endtask

  initial begin
    int f;
    repeat (3) @(negedge clk);
    check("reset_bit_cmd", 32'(bit_cmd), NOP);
    check("reset_cmd_ack", 32'(cmd_ack), 0);
    check("reset_ack_out", 32'(ack_out), 0);
    check("reset_dout", 32'(dout), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_al", 32'(al), 0);
    check("reset_bit_din", 32'(bit_din), 1);
    rstn = 1'b1;
    @(negedge clk);

    // start + write A5, slave ACKs
    run_cmd(1, 0, 0, 1, 8'hA5, 0, -1, 0, -1, -1, -1, 0);
    check("t1_ack_out", 32'(ack_out), 0);
    // read with NACK and stop, slave returns 6C
    run_cmd(0, 1, 1, 0, 8'h00, 1, 8'h6C, -1, -1, -1, -1, 0);
    check("t2_dout", 32'(dout), 32'h6C);
    // bare stop, bare start
    run_cmd(0, 1, 0, 0, 8'h00, 0, -1, -1, -1, -1, -1, 0);
    run_cmd(1, 0, 0, 0, 8'h00, 0, -1, -1, -1, -1, -1, 0);
    // arbitration lost on the 4th data bit (index 4 after START)
    run_cmd(1, 0, 0, 1, 8'h3C, 0, -1, -1, 4, -1, -1, 0);
    run_cmd(0, 0, 0, 1, 8'h81, 0, -1, 1, -1, -1, -1, 0);
    // host holds write past cmd_ack; read+write together takes the read path
    run_cmd(0, 0, 0, 1, 8'h5A, 0, -1, -1, -1, -1, -1, 1);
    run_cmd(0, 0, 1, 1, 8'hFF, 0, 8'h12, -1, -1, -1, -1, 0);
    // ena low for 20 cycles mid-read, reset pulse mid-write
    run_cmd(1, 1, 1, 0, 8'h00, 0, -1, -1, -1, 4, -1, 0);
    run_cmd(1, 0, 0, 1, 8'hC3, 0, -1, -1, -1, -1, 5, 0);
    run_cmd(0, 0, 0, 1, 8'h96, 0, -1, -1, -1, -1, -1, 0);

    for (int k = 0; k < 30; k++) begin
      f = $urandom_range(1, 15);
      run_cmd(f[0], f[1], f[2], f[3], 8'($urandom_range(0, 255)), 1'($urandom),
              -1, -1, -1, -1, -1, 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
